// File: rtl/psu_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psu_accum_pkg
// Purpose  : Shared types, default widths and saturation helpers for the
//            partial-sum accumulator (psu_accum) and its clamp (psu_sat).
// Contents : PSU_DW_DEF / ACC_DW_DEF   default widths
//            psu_state_e               group state (IDLE = first beat next)
//            sat_res_t                 clamp result {ovf, val}
//            sat_to()                  signed clamp of a 64-bit value to W bits
//            sext_psu()                sign-extend the low W bits to 64 bits
// Revision : 1.0 - initial release
// ============================================================================
package psu_accum_pkg;

    // Default hardware partial-sum width; the accumulator is twice as wide.
    localparam int unsigned PSU_DW_DEF = 16;
    localparam int unsigned ACC_DW_DEF = 2 * PSU_DW_DEF;

    // The helpers work on a 64-bit signed carrier, so ACC_DW must stay <= 63
    // (the accumulator sum is ACC_DW+1 bits wide).
    localparam int unsigned SAT_CARRIER_W = 64;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_IDLE = 1'b1
    } psu_state_e;

    typedef struct packed {
        logic                          ovf;
        logic [SAT_CARRIER_W-1:0]      val;
    } sat_res_t;

    // Clamp v to the signed range of a w-bit number. w is a constant at every
    // call site, so the bounds fold to constants in hardware.
    function automatic sat_res_t sat_to(
        input logic signed [SAT_CARRIER_W-1:0] v,
        input int unsigned                     w
    );
        sat_res_t                       r;
        logic signed [SAT_CARRIER_W-1:0] hi;
        logic signed [SAT_CARRIER_W-1:0] lo;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

    // Sign-extend the low w bits of raw to the full carrier width.
    function automatic logic signed [SAT_CARRIER_W-1:0] sext_psu(
        input logic [SAT_CARRIER_W-1:0] raw,
        input int unsigned              w
    );
        logic signed [SAT_CARRIER_W-1:0] t;
        t = signed'(raw << (SAT_CARRIER_W - w));
        return t >>> (SAT_CARRIER_W - w);
    endfunction

endpackage : psu_accum_pkg
`default_nettype wire

// File: rtl/psu_sat.sv
`default_nettype none
// ============================================================================
// Module   : psu_sat
// Purpose  : Combinational arithmetic right shift followed by a signed clamp.
//            Used both for the accumulator clamp (SHIFT=0) and for the output
//            rounding-down + clamp to the partial-sum width.
// Ports    : din_i   in  IN_W   signed value to shift and clamp
//            dout_o  out OUT_W  clamped result
//            ovf_o   out 1      clamp was applied
// Revision : 1.0 - initial release
// ============================================================================
module psu_sat
    import psu_accum_pkg::*;
#(
    parameter int unsigned IN_W  = ACC_DW_DEF + 1,
    parameter int unsigned OUT_W = PSU_DW_DEF,
    parameter int unsigned SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    ovf_o
);

    logic signed [SAT_CARRIER_W-1:0] w_wide;
    logic signed [SAT_CARRIER_W-1:0] w_shifted;
    sat_res_t                        w_res;
    logic                            w_unused;

    always_comb begin
        w_wide    = sext_psu(SAT_CARRIER_W'(din_i), IN_W);
        // Arithmetic shift: truncation is toward minus infinity.
        w_shifted = w_wide >>> SHIFT;
        w_res     = sat_to(w_shifted, OUT_W);
    end

    assign dout_o = w_res.val[OUT_W-1:0];
    assign ovf_o  = w_res.ovf;

    // Upper carrier bits only ever hold the sign copy after the clamp.
    assign w_unused = ^w_res.val[SAT_CARRIER_W-1:OUT_W];

endmodule : psu_sat
`default_nettype wire

// File: rtl/psu_accum.sv
`default_nettype none
// ============================================================================
// Module   : psu_accum
// Purpose  : Per-lane accumulator of the signed partial-sum stream over a
//            reduction group (a run of beats ended by in_last). Emits one
//            shifted, saturated result per group on a valid/ready port.
// Ports    : clk        in  1       clock
//            rst_n      in  1       synchronous active-low reset
//            clr        in  1       synchronous abort of the partial group
//            psu_in     in  PSU_DW  signed partial sum
//            in_valid   in  1       psu_in valid
//            in_last    in  1       final beat of the group
//            in_ready   out 1       beat accepted when in_valid & in_ready
//            out_data   out PSU_DW  signed group result
//            out_valid  out 1       out_data valid
//            out_ready  in  1       downstream accept
//            sat_flag   out 1       sticky saturation since reset/clr
// Revision : 1.0 - initial release
// ============================================================================
module psu_accum
    import psu_accum_pkg::*;
#(
    parameter int unsigned PSU_DW = PSU_DW_DEF,
    parameter int unsigned ACC_DW = ACC_DW_DEF,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic signed [PSU_DW-1:0] psu_in,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [PSU_DW-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag
);

    psu_state_e                state_q,     state_d;
    logic signed [ACC_DW-1:0]  acc_q,       acc_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [PSU_DW-1:0]  out_data_q,  out_data_d;
    logic                      sat_flag_q,  sat_flag_d;

    logic                            w_accept;
    logic                            w_take;
    logic signed [SAT_CARRIER_W-1:0] w_ext64;
    logic signed [ACC_DW:0]          w_psu_ext;
    logic signed [ACC_DW:0]          w_acc_ext;
    logic signed [ACC_DW:0]          w_sum;
    logic signed [ACC_DW-1:0]        w_s;
    logic                            w_acc_ovf;
    logic signed [PSU_DW-1:0]        w_out;
    logic                            w_out_ovf;
    logic                            w_unused;

    // The whole input stalls only while a result is pending and not taken.
    assign in_ready = ~(out_valid_q & ~out_ready);
    assign w_take   = out_valid_q & out_ready;
    // clr outranks acceptance: a beat presented alongside clr is dropped.
    assign w_accept = in_valid & in_ready & ~clr;

    assign w_ext64   = sext_psu(SAT_CARRIER_W'(psu_in), PSU_DW);
    assign w_psu_ext = w_ext64[ACC_DW:0];
    assign w_acc_ext = {acc_q[ACC_DW-1], acc_q};
    assign w_unused  = ^w_ext64[SAT_CARRIER_W-1:ACC_DW+1];

    // The first beat of a group overwrites whatever acc holds from before.
    assign w_sum = (state_q == ST_IDLE) ? w_psu_ext : (w_acc_ext + w_psu_ext);

    psu_sat #(
        .IN_W  (ACC_DW + 1),
        .OUT_W (ACC_DW),
        .SHIFT (0)
    ) u_acc_sat (
        .din_i  (w_sum),
        .dout_o (w_s),
        .ovf_o  (w_acc_ovf)
    );

    psu_sat #(
        .IN_W  (ACC_DW + 1),
        .OUT_W (PSU_DW),
        .SHIFT (SHIFT)
    ) u_out_sat (
        .din_i  ({w_s[ACC_DW-1], w_s}),
        .dout_o (w_out),
        .ovf_o  (w_out_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_flag_d  = sat_flag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (clr) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            sat_flag_d = 1'b0;
        end else if (w_accept) begin
            acc_d      = w_s;
            state_d    = in_last ? ST_IDLE : ST_ACC;
            // Output clamp only matters on the beat that produces a result.
            sat_flag_d = sat_flag_q | w_acc_ovf | (in_last & w_out_ovf);
        end

        // A new result in the same cycle as a handshake keeps out_valid high,
        // so single-beat groups stream at one result per cycle.
        if (w_accept && in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = w_out;
        end else if (w_take) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;

endmodule : psu_accum
`default_nettype wire
